// File: rtl/tram_writer_if.sv
// Character command stream in, tram write port out.
// The writer connects to the slave modport; the character source and tram sink use the master modport.
interface tram_writer_if #(
    parameter int WORD  = 32,
    parameter int ADDRW = 14,
    parameter int CIDXW = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [20:0]      cmd_ucp;
    logic [CIDXW-1:0] cmd_fg;
    logic [CIDXW-1:0] cmd_bg;
    logic             tram_we;
    logic [ADDRW-1:0] tram_addr;
    logic [WORD-1:0]  tram_data;

    modport master (
        output cmd_valid, cmd_ucp, cmd_fg, cmd_bg,
        input  cmd_ready, tram_we, tram_addr, tram_data
    );

    modport slave (
        input  cmd_valid, cmd_ucp, cmd_fg, cmd_bg,
        output cmd_ready, tram_we, tram_addr, tram_data
    );
endinterface

// File: rtl/tram_writer.sv
// Text RAM writer: turns character commands into tram writes, tracks the cursor,
// and scrolls by advancing the circular scroll_offs instead of copying memory.
module tram_writer #(
    parameter int WORD      = 32,
    parameter int ADDRW     = 14,
    parameter int CIDXW     = 4,
    parameter int TRAM_HRES = 80,
    parameter int TRAM_VRES = 30
) (
    input  logic             clk,
    input  logic             rst,
    tram_writer_if.slave     bus,
    output logic [ADDRW-1:0] scroll_offs,
    output logic [ADDRW-1:0] cur_x,
    output logic [ADDRW-1:0] cur_y
);
    localparam int TSIZE = TRAM_HRES * TRAM_VRES;

    localparam logic [ADDRW-1:0] ONE   = ADDRW'(1);
    localparam logic [ADDRW-1:0] HLAST = ADDRW'(TRAM_HRES - 1);
    localparam logic [ADDRW-1:0] VLAST = ADDRW'(TRAM_VRES - 1);
    localparam logic [ADDRW-1:0] TLAST = ADDRW'(TSIZE - 1);
    localparam logic [ADDRW:0]   HSTEP = (ADDRW+1)'(TRAM_HRES);
    localparam logic [ADDRW:0]   TSZW  = (ADDRW+1)'(TSIZE);

    localparam logic [20:0] C_BS    = 21'h08;
    localparam logic [20:0] C_LF    = 21'h0A;
    localparam logic [20:0] C_FF    = 21'h0C;
    localparam logic [20:0] C_CR    = 21'h0D;
    localparam logic [20:0] C_SPACE = 21'h20;
    localparam logic [20:0] C_DEL   = 21'h7F;

    typedef enum logic [1:0] {IDLE, EXEC, SCROLL, CLEAR} state_t;

    state_t           state;
    logic [ADDRW-1:0] line_base;
    logic [20:0]      ucp_q;
    logic [CIDXW-1:0] fg_q;
    logic [CIDXW-1:0] bg_q;

    logic             accept;
    logic             do_lf;
    logic [ADDRW-1:0] scroll_end;

    function automatic logic is_print(input logic [20:0] u);
        return (u >= C_SPACE) && (u != C_DEL);
    endfunction

    function automatic logic [WORD-1:0] mkword(input logic [20:0] u,
                                               input logic [CIDXW-1:0] f,
                                               input logic [CIDXW-1:0] b);
        logic [WORD-1:0] w;
        w = '0;
        w[WORD-1 -: CIDXW]       = b;
        w[WORD-CIDXW-1 -: CIDXW] = f;
        w[20:0]                  = u;
        return w;
    endfunction

    // Advance by one line, wrapping at TSIZE; computed one bit wider so it cannot overflow.
    function automatic logic [ADDRW-1:0] next_line(input logic [ADDRW-1:0] a);
        logic [ADDRW:0] s;
        s = {1'b0, a} + HSTEP;
        return (s >= TSZW) ? '0 : s[ADDRW-1:0];
    endfunction

    always_comb begin
        accept     = bus.cmd_valid && bus.cmd_ready;
        do_lf      = (ucp_q == C_LF) || (is_print(ucp_q) && (cur_x == HLAST));
        scroll_end = scroll_offs + HLAST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.tram_we   <= 1'b0;
            bus.tram_addr <= '0;
            bus.tram_data <= '0;
            scroll_offs   <= '0;
            cur_x         <= '0;
            cur_y         <= '0;
            line_base     <= '0;
            ucp_q         <= '0;
            fg_q          <= '0;
            bg_q          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.tram_we <= 1'b0;
                    if (accept) begin
                        ucp_q         <= bus.cmd_ucp;
                        fg_q          <= bus.cmd_fg;
                        bg_q          <= bus.cmd_bg;
                        bus.cmd_ready <= 1'b0;
                        // The character write is issued from here so it appears during EXEC.
                        if (bus.cmd_ucp == C_FF) begin
                            state         <= CLEAR;
                            bus.tram_we   <= 1'b1;
                            bus.tram_addr <= '0;
                            bus.tram_data <= mkword(C_SPACE, bus.cmd_fg, bus.cmd_bg);
                        end else begin
                            state <= EXEC;
                            if (is_print(bus.cmd_ucp)) begin
                                bus.tram_we   <= 1'b1;
                                bus.tram_addr <= line_base + cur_x;
                                bus.tram_data <= mkword(bus.cmd_ucp, bus.cmd_fg, bus.cmd_bg);
                            end
                        end
                    end
                end

                EXEC: begin
                    bus.tram_we <= 1'b0;
                    if (is_print(ucp_q)) begin
                        cur_x <= (cur_x == HLAST) ? '0 : cur_x + ONE;
                    end else if ((ucp_q == C_LF) || (ucp_q == C_CR)) begin
                        cur_x <= '0;
                    end else if ((ucp_q == C_BS) && (cur_x != '0)) begin
                        cur_x <= cur_x - ONE;
                    end

                    if (do_lf && (cur_y == VLAST)) begin
                        state         <= SCROLL;
                        bus.tram_we   <= 1'b1;
                        bus.tram_addr <= scroll_offs;
                        bus.tram_data <= mkword(C_SPACE, fg_q, bg_q);
                    end else begin
                        if (do_lf) begin
                            cur_y     <= cur_y + ONE;
                            line_base <= next_line(line_base);
                        end
                        state         <= IDLE;
                        bus.cmd_ready <= 1'b1;
                    end
                end

                SCROLL: begin
                    if (bus.tram_addr == scroll_end) begin
                        bus.tram_we   <= 1'b0;
                        scroll_offs   <= next_line(scroll_offs);
                        line_base     <= scroll_offs;
                        state         <= IDLE;
                        bus.cmd_ready <= 1'b1;
                    end else begin
                        bus.tram_addr <= bus.tram_addr + ONE;
                    end
                end

                CLEAR: begin
                    if (bus.tram_addr == TLAST) begin
                        bus.tram_we   <= 1'b0;
                        scroll_offs   <= '0;
                        line_base     <= '0;
                        cur_x         <= '0;
                        cur_y         <= '0;
                        state         <= IDLE;
                        bus.cmd_ready <= 1'b1;
                    end else begin
                        bus.tram_addr <= bus.tram_addr + ONE;
                    end
                end

                default: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                    bus.tram_we   <= 1'b0;
                end
            endcase
        end
    end
endmodule
